// File: rtl/gemm_pkg.sv
// rtl/gemm_pkg.sv - shared GEMM constants and the result-drain state type
package gemm_pkg;

  localparam int ACC_W  = 19;
  localparam int OPND_W = 8;
  localparam int Q_MIN  = -128;
  localparam int Q_MAX  = 127;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } drain_state_e;

endpackage

// File: rtl/drain_sat8.sv
// rtl/drain_sat8.sv - arithmetic shift then saturate to signed 8-bit, sign-extended back to ACC_W
module drain_sat8 #(
  parameter int ACC_W = gemm_pkg::ACC_W,
  parameter int SHIFT = 7
) (
  input  logic [ACC_W-1:0] acc_i,
  output logic [ACC_W-1:0] data_o,
  output logic             sat_o
);
  import gemm_pkg::*;

  localparam logic signed [ACC_W-1:0] HI = ACC_W'(Q_MAX);
  localparam logic signed [ACC_W-1:0] LO = ACC_W'(Q_MIN);

  logic signed [ACC_W-1:0] shifted;

  assign shifted = $signed(acc_i) >>> SHIFT;

  // Clamp the truncated quotient into the 8-bit range and flag any clamping
  always_comb begin
    data_o = shifted;
    sat_o  = 1'b0;
    if (shifted > HI) begin
      data_o = HI;
      sat_o  = 1'b1;
    end else if (shifted < LO) begin
      data_o = LO;
      sat_o  = 1'b1;
    end
  end

endmodule

// File: rtl/gemm_result_drain.sv
// rtl/gemm_result_drain.sv - snapshot a MAC row on capture and stream it out; DRAIN_SAT8_EN adds requantization
module gemm_result_drain #(
  parameter int NUM_MACS = 4,
  parameter int ACC_W    = gemm_pkg::ACC_W,
  parameter int SHIFT    = 7
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_MACS*ACC_W-1:0]   acc_in,
  input  logic                        capture,
  output logic                        busy,
  output logic                        capture_drop,
  output logic [ACC_W-1:0]            out_data,
  output logic [$clog2(NUM_MACS)-1:0] out_idx,
  output logic                        out_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_sat
);
  import gemm_pkg::*;

  localparam int               IDX_W    = $clog2(NUM_MACS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MACS - 1);

  if (NUM_MACS < 2) begin : g_bad_num_macs
    $error("gemm_result_drain: NUM_MACS must be at least 2");
  end
  if ((SHIFT < 0) || (SHIFT >= ACC_W)) begin : g_bad_shift
    $error("gemm_result_drain: SHIFT must lie in [0, ACC_W-1]");
  end

  drain_state_e                   state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [NUM_MACS-1:0][ACC_W-1:0] bank_q;
  logic [NUM_MACS-1:0][ACC_W-1:0] bank_in;
  logic                           load;
  logic                           drop_q, drop_d;

`ifdef DRAIN_SAT8_EN
  logic [NUM_MACS-1:0] sat_in;
  logic [NUM_MACS-1:0] sat_bank_q;

  // Requantize on the way into the bank so the output path adds no latency
  for (genvar g = 0; g < NUM_MACS; g++) begin : g_sat
    drain_sat8 #(
      .ACC_W (ACC_W),
      .SHIFT (SHIFT)
    ) u_drain_sat8 (
      .acc_i  (acc_in[g*ACC_W +: ACC_W]),
      .data_o (bank_in[g]),
      .sat_o  (sat_in[g])
    );
  end

  // Saturation flags travel with their values through the bank
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_bank_q <= '0;
    end else if (load) begin
      sat_bank_q <= sat_in;
    end
  end

  assign out_sat = (state_q == SEND) && sat_bank_q[idx_q];
`else
  assign bank_in = acc_in;
  assign out_sat = 1'b0;
`endif

  // Next-state: accept a snapshot when idle or on the final handshake, drop it otherwise
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    drop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (capture) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        drop_d = capture && !load;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State, beat index and drop pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drop_q  <= drop_d;
    end
  end

  // Snapshot bank: the whole row is taken in one cycle so the MACs are free immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q <= '0;
    end else if (load) begin
      bank_q <= bank_in;
    end
  end

  assign out_valid    = (state_q == SEND);
  assign busy         = out_valid;
  assign out_idx      = idx_q;
  assign out_last     = out_valid && (idx_q == LAST_IDX);
  assign out_data     = out_valid ? bank_q[idx_q] : '0;
  assign capture_drop = drop_q;

endmodule

// File: tb/tb_gemm_result_drain.sv
// tb/tb_gemm_result_drain.sv - self-checking bench for gemm_result_drain against a queue-based reference
module tb_gemm_result_drain;

  localparam int NUM_MACS = 4;
  localparam int ACC_W    = 19;
  localparam int SHIFT    = 7;
  localparam int IDX_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_MACS*ACC_W-1:0] acc_in;
  logic                      capture;
  logic                      busy;
  logic                      capture_drop;
  logic [ACC_W-1:0]          out_data;
  logic [IDX_W-1:0]          out_idx;
  logic                      out_last;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_sat;

  gemm_result_drain #(
    .NUM_MACS (NUM_MACS),
    .ACC_W    (ACC_W),
    .SHIFT    (SHIFT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .acc_in       (acc_in),
    .capture      (capture),
    .busy         (busy),
    .capture_drop (capture_drop),
    .out_data     (out_data),
    .out_idx      (out_idx),
    .out_last     (out_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_sat      (out_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ACC_W-1:0] val;
    logic             sat;
    int               idx;
  } beat_t;

  beat_t exp_q[$];
  int    cur_acc[NUM_MACS];
  int    errors = 0;
  int    checks = 0;

  function automatic logic [ACC_W-1:0] req_val(input int a);
`ifdef DRAIN_SAT8_EN
    int q;
    q = a >>> SHIFT;
    if (q > 127) q = 127;
    else if (q < -128) q = -128;
    return ACC_W'(q);
`else
    return ACC_W'(a);
`endif
  endfunction

  function automatic logic req_sat(input int a);
`ifdef DRAIN_SAT8_EN
    int q;
    q = a >>> SHIFT;
    return (q > 127) || (q < -128);
`else
    return (a != a);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_acc(input int a0, input int a1, input int a2, input int a3);
    cur_acc[0] = a0;
    cur_acc[1] = a1;
    cur_acc[2] = a2;
    cur_acc[3] = a3;
  endtask

  // One clock cycle: drive inputs, check the visible beat, advance the model, then check the drop pulse
  task automatic cycle(input logic cap, input logic rdy);
    beat_t b;
    logic  exp_drop;
    capture   = cap;
    out_ready = rdy;
    for (int i = 0; i < NUM_MACS; i++) acc_in[i*ACC_W +: ACC_W] = ACC_W'(cur_acc[i]);
    #1;
    check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
    check("busy", 32'(busy), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      b = exp_q[0];
      check("out_data", 32'(out_data), 32'(b.val));
      check("out_idx", 32'(out_idx), 32'(b.idx));
      check("out_last", 32'(out_last), 32'(b.idx == NUM_MACS - 1));
      check("out_sat", 32'(out_sat), 32'(b.sat));
    end
    if (rdy && exp_q.size() > 0) void'(exp_q.pop_front());
    exp_drop = cap && (exp_q.size() != 0);
    if (cap && exp_q.size() == 0) begin
      for (int i = 0; i < NUM_MACS; i++) begin
        b.val = req_val(cur_acc[i]);
        b.sat = req_sat(cur_acc[i]);
        b.idx = i;
        exp_q.push_back(b);
      end
    end
    @(posedge clk);
    #1;
    capture = 1'b0;
    check("capture_drop", 32'(capture_drop), 32'(exp_drop));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_data"}, 32'(out_data), 32'd0);
    check({tag, "_idx"}, 32'(out_idx), 32'd0);
    check({tag, "_last"}, 32'(out_last), 32'd0);
    check({tag, "_sat"}, 32'(out_sat), 32'd0);
    check({tag, "_drop"}, 32'(capture_drop), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    capture   = 1'b0;
    out_ready = 1'b0;
    acc_in    = '0;
    set_acc(0, 0, 0, 0);
    #3;
    check_reset_outputs("reset");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(1'b0, 1'b0);

    // Basic drain with extreme values, MAC0 first
    set_acc(100, -5, 262143, -262144);
    cycle(1'b1, 1'b1);
    repeat (4) cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);

    // Backpressure: ready pattern 0,0,1 per beat
    set_acc(11, -22, 33, -44);
    cycle(1'b1, 1'b0);
    repeat (4) begin
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b0);
      cycle(1'b0, 1'b1);
    end
    cycle(1'b0, 1'b0);

    // Capture while busy on the idx 1 beat is dropped
    set_acc(7, 8, 9, 10);
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    set_acc(-1, -2, -3, -4);
    cycle(1'b1, 1'b1);
    repeat (3) cycle(1'b0, 1'b1);

    // Back-to-back tiles: reload on the idx 3 handshake
    set_acc(500, 600, 700, 800);
    cycle(1'b1, 1'b1);
    repeat (3) cycle(1'b0, 1'b1);
    set_acc(1, 2, 3, 4);
    cycle(1'b1, 1'b1);
    repeat (4) cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);

    // Reset during the idx 2 beat aborts the drain at once
    set_acc(-77, 88, -99, 111);
    cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle(1'b0, 1'b1);
    set_acc(1000, -1000, 2000, -2000);
    cycle(1'b1, 1'b1);
    repeat (4) cycle(1'b0, 1'b1);

`ifdef DRAIN_SAT8_EN
    // Requantization: in-range values, then clamped extremes
    set_acc(12800, -12800, 16256, -32);
    cycle(1'b1, 1'b1);
    repeat (4) cycle(1'b0, 1'b1);
    set_acc(262143, -262144, 127, 128);
    cycle(1'b1, 1'b1);
    repeat (4) cycle(1'b0, 1'b1);
`endif

    // Randomized traffic with random backpressure and captures
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < NUM_MACS; i++) cur_acc[i] = int'($urandom_range(0, 524287)) - 262144;
      end
      cycle(($urandom_range(0, 4) == 0), ($urandom_range(0, 3) != 0));
    end
    repeat (8) cycle(1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gemm_result_drain.md
# gemm_result_drain

Result-drain engine at the output end of the GEMM MAC array. On a single `capture` pulse it snapshots the accumulator value of every MAC in the row. It then streams the snapshot out one result per beat over a valid/ready interface, lowest MAC index first. Because the snapshot is taken in one cycle, the MACs are released immediately and can clear and start the next tile while the previous tile is still draining.

## Interface
- `NUM_MACS`, default 4: number of MAC accumulators captured per tile; must be ≥2.
- `ACC_W`, default 19: accumulator width, signed two's complement.
- `SHIFT`, default 7: arithmetic right shift applied before saturation; used only with `DRAIN_SAT8_EN`.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `acc_in`  in  NUM_MACS*ACC_W  accumulator bus; MAC i occupies `[i*ACC_W +: ACC_W]`.
- `capture`  in  1  one-cycle pulse from the sequencer: the accumulators are final, take a snapshot.
- `busy`  out  1  high while a snapshot is held and not yet fully drained.
- `capture_drop`  out  1  one-cycle pulse: a `capture` arrived while busy and was not accepted.
- `out_data`  out  ACC_W  result value (signed).
- `out_idx`  out  clog2(NUM_MACS)  MAC index of the current beat.
- `out_last`  out  1  high on the beat where `out_idx == NUM_MACS-1`.
- `out_valid`  out  1  beat valid.
- `out_ready`  in  1  downstream accepts the beat.
- `out_sat`  out  1  current beat was saturated; tied to 0 without `DRAIN_SAT8_EN`.

## Operation
- FSM states are `IDLE` and `SEND`.
- `IDLE`:
  - `busy=0`, `out_valid=0`.
  - On `capture`: latch all NUM_MACS slices into the snapshot bank, set `idx=0`, go to `SEND`.
- `SEND`:
  - `out_valid=1`; `out_data` and `out_sat` are derived from `bank[idx]`; `out_idx=idx`.
  - Handshake fires when `out_valid && out_ready`. On a handshake with `idx<NUM_MACS-1`, `idx` increments.
  - On a handshake with `idx==NUM_MACS-1`: if `capture` is also high, reload the bank, set `idx=0` and stay in `SEND` (back-to-back tiles, no bubble). Otherwise return to `IDLE`.
- A `capture` that arrives in `SEND` outside the final handshake cycle is ignored: the bank is untouched and `capture_drop` pulses for one cycle.
- Valid/ready rules:
  - `out_valid` never drops without a handshake.
  - `out_data`, `out_idx`, `out_last` and `out_sat` stay stable while `out_valid && !out_ready`.
  - `out_ready` may be asserted before `out_valid`.
- Arithmetic: no arithmetic without the macro; values pass through bit-exact.

## Timing
- Reset values:
  - `busy=0`, `capture_drop=0`, `out_valid=0`, `out_last=0`, `out_sat=0`.
  - `out_data=0`, `out_idx=0`, bank all-zero, state `IDLE`.
- Latency: `capture` sampled at edge N gives the first beat (idx 0) valid after edge N, i.e. in cycle N+1. `acc_in` is sampled at edge N only.
- Throughput: one beat per cycle while `out_ready=1`. A tile drains in NUM_MACS cycles, and the next tile can be accepted on the last beat.
- Backpressure: stalls hold the state indefinitely with no loss.
- Reset asserted mid-drain aborts the drain immediately: outputs go to their reset values asynchronously, and the remaining beats are discarded.
- `busy` rises in the same cycle as the first `out_valid` and falls after the last handshake, unless a back-to-back reload occurs, in which case it stays high.

## Configuration
- `DRAIN_SAT8_EN` defined:
  - Each output is `acc >>> SHIFT` (arithmetic shift, truncating), saturated to [-128, 127], then sign-extended to ACC_W.
  - `out_sat=1` when clamping occurred.
  - Requantization is applied at capture time and the requantized value is stored in the bank, so there is no added output latency.
- `DRAIN_SAT8_EN` undefined: raw ACC_W values are output and `out_sat` is constant 0.

## Structure
- Shared package `gemm_pkg` holds:
  - constants `ACC_W=19`, `OPND_W=8`, `Q_MIN=-128`, `Q_MAX=127`;
  - the drain state enum typedef (`IDLE`, `SEND`).
- One combinational sub-module, `drain_sat8`, holds the shift-and-saturate logic. It is instantiated NUM_MACS times at the bank input, only under `DRAIN_SAT8_EN`.

## Test plan
All scenarios use NUM_MACS=4.
- **Basic drain:** `acc_in={-262144, 262143, -5, 100}` (MAC3..MAC0), one `capture`, `out_ready=1` → beats 100, -5, 262143, -262144 with idx 0..3 in cycles N+1..N+4; `out_last` only on idx 3; `busy` falls after N+4.
- **Backpressure:** `out_ready` toggles 0,0,1 per beat → each beat is held stable for 3 cycles, no beat is lost or duplicated, total drain takes 12 cycles.
- **Capture during busy:** `capture` on the idx 1 beat → `capture_drop` pulses once, and the original values continue to drain unchanged.
- **Back-to-back:** second `capture` (new values 1, 2, 3, 4) on the idx 3 handshake → the next cycle is idx 0 = 1, with `out_valid` and `busy` never deasserting.
- **Reset mid-drain:** `rst_n` pulled low during idx 2 → `out_valid`, `busy` and `out_data` go to 0 at once; after release the block sits in `IDLE` and a new `capture` drains correctly from idx 0.
- **`DRAIN_SAT8_EN`, SHIFT=7:** inputs 12800, -12800, 16256, -32 → outputs 100 (`sat=0`), -100 (`sat=0`), 127 (`sat=0`), -1 (`sat=0`); input 262143 → 127 with `out_sat=1`.
